// File: rtl/i2s_adc_rx_if.sv
// Parallel sample bus produced by the I2S ADC receiver and consumed by the gain stage.
interface i2s_adc_rx_if;
    logic [15:0] Left_out;
    logic [15:0] Right_out;
    logic [15:0] Data_out;
    logic        Sample_valid;
    logic        Frame_err;

    modport master (
        output Left_out, Right_out, Data_out, Sample_valid, Frame_err
    );
    modport slave (
        input  Left_out, Right_out, Data_out, Sample_valid, Frame_err
    );
endinterface

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: oversamples the codec pins in the Clk domain and deserializes
// 16-bit left/right words into parallel samples plus a mono mix.
module i2s_adc_rx (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AUD_BCLK,
    input  logic         AUD_ADCLRCK,
    input  logic         AUD_ADCDAT,
    i2s_adc_rx_if.master smp
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        PAD
    } state_t;

    state_t      state_q;
    logic        bclk_s1_q, bclk_s2_q, bclk_h_q;
    logic        lr_s1_q, lr_s2_q, lr_h_q;
    logic        dat_s1_q, dat_s2_q;
    logic        chan_q;            // 0 = left slot, 1 = right slot
    logic [3:0]  cnt_q;
    logic [15:0] shift_q;
    logic [15:0] left_hold_q, right_hold_q;
    logic        left_ok_q;
    logic        frame_done_q;
    logic [15:0] left_out_q, right_out_q, data_out_q;
    logic        sample_valid_q, frame_err_q;

    logic        bclk_rise;
    logic        lr_edge;
    logic [15:0] word_d;
    logic [16:0] mix_sum;

    always_comb begin
        bclk_rise = bclk_s2_q & ~bclk_h_q;
        lr_edge   = lr_s2_q ^ lr_h_q;
        word_d    = {shift_q[14:0], dat_s2_q};
        mix_sum   = {left_hold_q[15], left_hold_q} + {right_hold_q[15], right_hold_q};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            bclk_s1_q      <= 1'b0;
            bclk_s2_q      <= 1'b0;
            bclk_h_q       <= 1'b0;
            lr_s1_q        <= 1'b0;
            lr_s2_q        <= 1'b0;
            lr_h_q         <= 1'b0;
            dat_s1_q       <= 1'b0;
            dat_s2_q       <= 1'b0;
        end else begin
            bclk_s1_q      <= AUD_BCLK;
            bclk_s2_q      <= bclk_s1_q;
            bclk_h_q       <= bclk_s2_q;
            lr_s1_q        <= AUD_ADCLRCK;
            lr_s2_q        <= lr_s1_q;
            lr_h_q         <= lr_s2_q;
            dat_s1_q       <= AUD_ADCDAT;
            dat_s2_q       <= dat_s1_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            chan_q         <= 1'b0;
            cnt_q          <= '0;
            shift_q        <= '0;
            left_hold_q    <= '0;
            right_hold_q   <= '0;
            left_ok_q      <= 1'b0;
            frame_done_q   <= 1'b0;
            left_out_q     <= '0;
            right_out_q    <= '0;
            data_out_q     <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_done_q   <= 1'b0;

            if (frame_done_q) begin
                left_out_q     <= left_hold_q;
                right_out_q    <= right_hold_q;
                data_out_q     <= mix_sum[16:1];
                sample_valid_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (lr_edge && !lr_s2_q) begin
                        state_q <= DELAY;
                        chan_q  <= 1'b0;
                    end
                end
                DELAY, SHIFT: begin
                    // An LRCK edge here means the slot ended short: drop the partial frame.
                    if (lr_edge) begin
                        frame_err_q <= 1'b1;
                        left_ok_q   <= 1'b0;
                        cnt_q       <= '0;
                        if (!lr_s2_q) begin
                            state_q <= DELAY;
                            chan_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (bclk_rise) begin
                        if (state_q == DELAY) begin
                            state_q <= SHIFT;
                            cnt_q   <= '0;
                        end else begin
                            shift_q <= word_d;
                            cnt_q   <= cnt_q + 4'd1;
                            if (cnt_q == 4'd15) begin
                                state_q <= PAD;
                                if (!chan_q) begin
                                    left_hold_q <= word_d;
                                    left_ok_q   <= 1'b1;
                                end else if (left_ok_q) begin
                                    right_hold_q <= word_d;
                                    left_ok_q    <= 1'b0;
                                    frame_done_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                PAD: begin
                    if (lr_edge) begin
                        state_q <= DELAY;
                        chan_q  <= lr_s2_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign smp.Left_out     = left_out_q;
    assign smp.Right_out    = right_out_q;
    assign smp.Data_out     = data_out_q;
    assign smp.Sample_valid = sample_valid_q;
    assign smp.Frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Scoreboard bench for i2s_adc_rx: directed I2S frames with hand-computed results.
module tb_i2s_adc_rx;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic bclk = 1'b0;
    logic lrck = 1'b0;
    logic adat = 1'b0;

    always #5 clk = ~clk;

    i2s_adc_rx_if bus ();

    i2s_adc_rx dut (
        .Clk         (clk),
        .Reset       (rst),
        .AUD_BCLK    (bclk),
        .AUD_ADCLRCK (lrck),
        .AUD_ADCDAT  (adat),
        .smp         (bus)
    );

    typedef struct {
        logic        err;
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] d;
    } ev_t;

    ev_t         sb[$];
    int          vecs = 0;
    int          errs = 0;
    logic [15:0] last_l = '0;
    logic [15:0] last_r = '0;
    logic [15:0] last_d = '0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        vecs++;
        if (bus.Left_out !== 16'h0000 || bus.Right_out !== 16'h0000 || bus.Data_out !== 16'h0000
            || bus.Sample_valid !== 1'b0 || bus.Frame_err !== 1'b0) begin
            errs++;
            $display("FAIL %s: got L=%h R=%h D=%h v=%b e=%b, need all zero",
                     name, bus.Left_out, bus.Right_out, bus.Data_out, bus.Sample_valid, bus.Frame_err);
        end
        last_l = '0;
        last_r = '0;
        last_d = '0;
    endtask

    // One slot: bit 0 is the I2S delay bit (driven 1 so it must be ignored), then MSB-first word, then zero pad.
    task automatic slot(input logic lr, input logic [15:0] w, input int nbits, input int half, input int rst_bit);
        for (int i = 0; i < nbits; i++) begin
            if (i == 0) lrck = lr;
            adat = (i == 0) ? 1'b1 : ((i <= 16) ? w[16 - i] : 1'b0);
            wait_clk(half);
            bclk = 1'b1;
            if (i == rst_bit) begin
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
                wait_clk(1);
                check_zero("reset_mid_frame");
            end
            wait_clk(half);
            bclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input logic [15:0] d,
                         input int nbits, input int half);
        ev_t e;
        e.err = 1'b0;
        e.l   = l;
        e.r   = r;
        e.d   = d;
        sb.push_back(e);
        last_l = l;
        last_r = r;
        last_d = d;
        slot(1'b0, l, nbits, half, -1);
        slot(1'b1, r, nbits, half, -1);
    endtask

    task automatic expect_err();
        ev_t e;
        e.err = 1'b1;
        e.l   = last_l;
        e.r   = last_r;
        e.d   = last_d;
        sb.push_back(e);
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (bus.Sample_valid === 1'b1 || bus.Frame_err === 1'b1) begin
                vecs++;
                if (bus.Sample_valid === 1'b1 && bus.Frame_err === 1'b1) begin
                    errs++;
                    $display("FAIL both_pulses: got valid=1 err=1, need at most one");
                end else if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_event: got valid=%b err=%b L=%h R=%h D=%h, need no event",
                             bus.Sample_valid, bus.Frame_err, bus.Left_out, bus.Right_out, bus.Data_out);
                end else begin
                    e = sb.pop_front();
                    if (bus.Frame_err !== e.err || bus.Left_out !== e.l
                        || bus.Right_out !== e.r || bus.Data_out !== e.d) begin
                        errs++;
                        $display("FAIL event: got err=%b L=%h R=%h D=%h, need err=%b L=%h R=%h D=%h",
                                 bus.Frame_err, bus.Left_out, bus.Right_out, bus.Data_out,
                                 e.err, e.l, e.r, e.d);
                    end
                end
            end
        end
    end

    initial begin
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        check_zero("reset_state");

        // Stream joins mid-right-slot; only the following full frame may produce output.
        slot(1'b1, 16'hBEEF, 12, 8, -1);
        frame(16'h1234, 16'hEDCC, 16'h0000, 32, 8);
        frame(16'h7FFF, 16'h7FFF, 16'h7FFF, 32, 8);
        frame(16'h8000, 16'h8000, 16'h8000, 32, 8);
        frame(16'h0001, 16'h0000, 16'h0000, 32, 8);
        frame(16'hFFFF, 16'h0000, 16'hFFFF, 32, 8);

        // Short left slot of 10 BCLKs: error pulse, outputs hold, right slot ignored.
        expect_err();
        slot(1'b0, 16'hAAAA, 10, 8, -1);
        slot(1'b1, 16'h5555, 32, 8, -1);
        frame(16'h0F0F, 16'hF0F0, 16'hFFFF, 32, 8);

        // Reset during the right word's shift: that frame is lost.
        slot(1'b0, 16'h1111, 32, 8, -1);
        slot(1'b1, 16'h2222, 32, 8, 8);
        frame(16'h0100, 16'h0300, 16'h0200, 32, 8);

        // Minimal 17-bit slots back to back at BCLK = Clk/8.
        frame(16'hA5A5, 16'h5A5A, 16'hFFFF, 17, 4);
        frame(16'h0002, 16'h0004, 16'h0003, 17, 4);
        frame(16'hFFFE, 16'hFFFC, 16'hFFFD, 17, 4);
        frame(16'h4000, 16'h4000, 16'h4000, 17, 4);

        for (int i = 0; i < 500 && sb.size() > 0; i++) wait_clk(1);
        if (sb.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL drain: got %0d events still pending, need 0", sb.size());
        end
        wait_clk(20);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
